// File: rtl/controle_de_partida.sv
// rtl/controle_de_partida.sv - match sequencing FSM driving the attack manager
module controle_de_partida #(
  parameter int VIDAS_INICIAIS = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic        confirmar_btn,
  input  logic [34:0] mapa_flat,
  input  logic        acerto,
  output logic        enable_ataque,
  output logic        confirmar_out,
  output logic [2:0]  vidas,
  output logic [5:0]  alvos_restantes,
  output logic        vitoria,
  output logic        derrota,
  output logic [2:0]  estado
);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    PREPARA  = 3'd1,
    AGUARDA  = 3'd2,
    DISPARA  = 3'd3,
    AVALIA   = 3'd4,
    VITORIA  = 3'd5,
    DERROTA  = 3'd6,
    REINICIA = 3'd7
  } estado_t;

  localparam logic [2:0] VIDAS_INI = 3'(VIDAS_INICIAIS);

  estado_t     estado_q, estado_d;
  logic [2:0]  vidas_q, vidas_d;
  logic [5:0]  alvos_q, alvos_d;
  logic        iniciar_ant_q, iniciar_ant_d;
  logic        confirmar_ant_q, confirmar_ant_d;
  logic        ini_edge, conf_edge;
  logic [5:0]  alvos_dec;
  logic [2:0]  vidas_dec;

  // Number of ship cells in the 35-cell map.
  function automatic logic [5:0] popcount(input logic [34:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 35; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

  // State, counters and button history registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q        <= OCIOSO;
      vidas_q         <= VIDAS_INI;
      alvos_q         <= '0;
      iniciar_ant_q   <= 1'b0;
      confirmar_ant_q <= 1'b0;
    end else begin
      estado_q        <= estado_d;
      vidas_q         <= vidas_d;
      alvos_q         <= alvos_d;
      iniciar_ant_q   <= iniciar_ant_d;
      confirmar_ant_q <= confirmar_ant_d;
    end
  end

  // Next-state and counter update; decrements saturate at zero.
  always_comb begin
    estado_d        = estado_q;
    vidas_d         = vidas_q;
    alvos_d         = alvos_q;
    iniciar_ant_d   = iniciar;
    confirmar_ant_d = confirmar_btn;
    ini_edge        = iniciar & ~iniciar_ant_q;
    conf_edge       = confirmar_btn & ~confirmar_ant_q;
    alvos_dec       = (alvos_q != 6'd0) ? alvos_q - 6'd1 : 6'd0;
    vidas_dec       = (vidas_q != 3'd0) ? vidas_q - 3'd1 : 3'd0;

    case (estado_q)
      OCIOSO: begin
        if (ini_edge) estado_d = PREPARA;
      end
      PREPARA: begin
        vidas_d  = VIDAS_INI;
        alvos_d  = popcount(mapa_flat);
        estado_d = (popcount(mapa_flat) == 6'd0) ? VITORIA : AGUARDA;
      end
      AGUARDA: begin
        // A restart request beats a simultaneous fire press.
        if (ini_edge)       estado_d = REINICIA;
        else if (conf_edge) estado_d = DISPARA;
      end
      DISPARA: begin
        estado_d = AVALIA;
      end
      AVALIA: begin
        if (acerto) begin
          alvos_d  = alvos_dec;
          estado_d = (alvos_dec == 6'd0) ? VITORIA : AGUARDA;
        end else begin
          vidas_d  = vidas_dec;
          estado_d = (vidas_dec == 3'd0) ? DERROTA : AGUARDA;
        end
      end
      VITORIA, DERROTA: begin
        if (ini_edge) estado_d = REINICIA;
      end
      REINICIA: begin
        estado_d = PREPARA;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    enable_ataque   = (estado_q != OCIOSO) && (estado_q != REINICIA);
    confirmar_out   = (estado_q == DISPARA);
    vitoria         = (estado_q == VITORIA);
    derrota         = (estado_q == DERROTA);
    estado          = estado_q;
    vidas           = vidas_q;
    alvos_restantes = alvos_q;
  end

endmodule
